lamp_fpu_sqrt_iter: RTL and testbench
=====================================

Name: lamp_fpu_sqrt_iter

Overview:
- Parametrised, iterative square-root unit for the lampFPU. Replaces the fixed-format sqrt wrapper with a self-contained radix-2 restoring digit-recurrence core.
- Adds valid/ready handshake, back-pressure, kill, and IEEE invalid signalling.
- Consumes unpacked operand fields from the FPU front end. Delivers a pre-rounding result (01.F G R S layout) to the shared rounding stage.

Parameters:
- E_DW, 8, exponent field width
- F_DW, 7, fraction field width (hidden bit excluded); F_DW < BIAS required
- BIAS, 2**(E_DW-1)-1, exponent bias
- ITERS (localparam), F_DW+3, recurrence iterations (1 integer + F_DW fraction + G + R)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- valid_i  in  1  operand valid
- ready_o  out  1  unit can accept operand
- kill_i  in  1  abort in-flight operation
- s_i  in  1  operand sign
- extF_i  in  F_DW+1  significand incl. hidden bit (0 for subnormal)
- extE_i  in  E_DW+1  biased exponent (1 for subnormal)
- nlz_i  in  $clog2(F_DW+1)  leading zeros of extF_i
- isZ_i, isInf_i, isSNAN_i, isQNAN_i  in  1 each  operand class flags
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- s_res_o  out  1  result sign
- e_res_o  out  E_DW  result biased exponent
- f_res_o  out  F_DW+5  {0,1,frac[F_DW-1:0],G,R,S}
- isToRound_o  out  1  result requires rounding
- invalid_o  out  1  IEEE invalid-operation flag
- isOverflow_o, isUnderflow_o  out  1 each  tied 0 (sqrt cannot over/underflow when F_DW < BIAS)

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. While rst is high, ready_o=0 and all outputs are 0; FSM goes to IDLE. ready_o=1 from the first cycle after rst deasserts.
- FSM states: IDLE, ITER, DONE.
  - IDLE: ready_o=1. On valid_i&&ready_o (accept cycle T), register operand and go to ITER.
  - ITER: ready_o=0. Counter runs 0..ITERS-1; at count ITERS-1, go to DONE.
  - DONE: valid_o=1 with outputs held stable. On ready_i, go to IDLE (ready_o=1 the following cycle).
- Latency: valid_o first high at T+ITERS+1. No new accept before the result is taken. Throughput is 1 op per ITERS+2 cycles minimum.
- Exponent preparation at accept:
  - ue = extE_i - nlz_i - BIAS, signed, E_DW+2 bits.
  - mant = extF_i << nlz_i (normalised 1.xxx).
  - ue odd: radicand = mant<<1, ue' = ue-1. ue even: radicand = mant, ue' = ue.
  - e_res_o = ue'/2 + BIAS (arithmetic shift).
  - The root lies in [1,2), so no post-normalisation is needed.
- Recurrence: each ITER cycle resolves one root bit, MSB first (restoring: trial = rem<<2 | next radicand pair, minus {root,01}). After the last iteration, S = (remainder != 0). f_res_o = {1'b0, root[ITERS-1:0], S}.
- Special cases: decided at accept, using the registered class flags.
  - sNaN or qNaN: result QNaN (s=0, e all ones, frac = 1<<(F_DW-1)). invalid_o = isSNAN.
  - Negative non-zero, including -inf: QNaN, invalid_o=1.
  - ±0: ±0.
  - +inf: +inf.
  - For all special results: isToRound_o=0. f_res_o carries the final fraction field in bits [F_DW+2:3]; all other bits are 0.
- Normal results: isToRound_o=1, invalid_o=0, s_res_o=0.
- kill_i:
  - In ITER or DONE: go to IDLE next cycle; valid_o=0 next cycle; no result is delivered.
  - kill_i has priority over ready_i.
  - kill_i together with valid_i in IDLE: the operand is not accepted.
- rst mid-operation: immediate abort, as at reset.
- valid_o && !ready_i: all result outputs stay constant indefinitely.

Optional Feature:
- Macro: LAMP_SQRT_EARLY_EXIT_EN.
- Defined: special-case operands skip ITER (IDLE->DONE). valid_o is high at T+1.
- Undefined: every operand traverses ITER, giving fixed latency ITERS+1 for all inputs (deterministic scheduling). Special-case outputs are identical either way.

Test Plan:
- sqrt(4.0), bf16 0x4080 (s=0, extE=129, extF=0x80, nlz=0) -> e_res_o=128, f_res_o=12'h400, isToRound_o=1. valid_o at T+11 (E_DW=8, F_DW=7).
- sqrt(2.0), extE=128, extF=0x80 -> e_res_o=127, f_res_o=12'h5A9 (frac 0110101, G=0, R=0, S=1).
- Subnormal 0x0001 (extE=1, extF=0x01, nlz=7) -> e_res_o=60, f_res_o=12'h5A9.
- -1.0 (s=1, extE=127, extF=0x80) -> s=0, e=0xFF, frac field 0x40, invalid_o=1, isToRound_o=0. Valid at T+1 with LAMP_SQRT_EARLY_EXIT_EN, T+11 without. -0 -> s=1, e=0, f=0.
- Back-pressure: hold ready_i=0 for 5 cycles after valid_o -> outputs stable, ready_o=0. Pulse ready_i -> ready_o=1 next cycle. A second operand is then accepted.
- kill_i at iteration 4 -> IDLE next cycle, valid_o never asserts. An immediately following sqrt(4.0) returns a correct result.

Source files
------------

// File: rtl/lamp_fpu_sqrt_iter.sv
// lamp_fpu_sqrt_iter: iterative radix-2 restoring square-root unit for the lampFPU.
// Takes unpacked operand fields, produces a pre-rounding result {0,1,frac,G,R,S}
// for the shared rounding stage, with valid/ready handshake and kill.
// Optional build macro: LAMP_SQRT_EARLY_EXIT_EN -- when defined, special-case
// operands bypass the iteration phase and are delivered one cycle after accept.
module lamp_fpu_sqrt_iter #(
   parameter int E_DW = 8,
   parameter int F_DW = 7,
   parameter int BIAS = 2**(E_DW-1)-1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        valid_i,
   output logic                        ready_o,
   input  logic                        kill_i,
   input  logic                        s_i,
   input  logic [F_DW:0]               extF_i,
   input  logic [E_DW:0]               extE_i,
   input  logic [$clog2(F_DW+1)-1:0]   nlz_i,
   input  logic                        isZ_i,
   input  logic                        isInf_i,
   input  logic                        isSNAN_i,
   input  logic                        isQNAN_i,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic                        s_res_o,
   output logic [E_DW-1:0]             e_res_o,
   output logic [F_DW+4:0]             f_res_o,
   output logic                        isToRound_o,
   output logic                        invalid_o,
   output logic                        isOverflow_o,
   output logic                        isUnderflow_o
);

   localparam int ITERS = F_DW + 3;
   localparam int UE_W  = E_DW + 2;
   localparam int RAD_W = 2 * ITERS;
   localparam int REM_W = ITERS + 3;
   localparam int CNT_W = $clog2(ITERS);

   localparam logic [UE_W-1:0]  BIAS_UE   = UE_W'(BIAS);
   localparam logic [F_DW-1:0]  QNAN_FRAC = {1'b1, {(F_DW-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(ITERS-1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ITER = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [RAD_W-1:0] r_rad;
   logic [REM_W-1:0] r_rem;
   logic [ITERS-1:0] r_root;
   logic             r_special;
   logic             r_s;
   logic [E_DW-1:0]  r_e;
   logic [F_DW-1:0]  r_fracSp;
   logic             r_invalid;
   logic             r_isToRound;

   logic             w_accept;
   logic [F_DW:0]    w_mant;
   logic [UE_W-1:0]  w_ue;
   logic [UE_W-1:0]  w_ueEven;
   logic [UE_W-1:0]  w_eHalf;
   logic [E_DW-1:0]  w_eNorm;
   logic [RAD_W-1:0] w_rad;
   logic             w_special;
   logic             w_sSp;
   logic [E_DW-1:0]  w_eSp;
   logic [F_DW-1:0]  w_fracSp;
   logic             w_invSp;
   logic [REM_W-1:0] w_remSh;
   logic [REM_W:0]   w_trial;
   logic             w_trialNeg;

   assign w_accept = (r_state == ST_IDLE) && valid_i && !kill_i;

   // Operand normalisation: unbiased exponent made even, radicand aligned so the root lies in [1,2)
   always_comb begin
      w_mant   = extF_i << nlz_i;
      w_ue     = {1'b0, extE_i} - UE_W'(nlz_i) - BIAS_UE;
      w_ueEven = {w_ue[UE_W-1:1], 1'b0};
      w_eHalf  = {w_ueEven[UE_W-1], w_ueEven[UE_W-1:1]};
      w_eNorm  = E_DW'(w_eHalf + BIAS_UE);
      if (w_ue[0])
         w_rad = {w_mant, {(RAD_W-F_DW-1){1'b0}}};
      else
         w_rad = {1'b0, w_mant, {(RAD_W-F_DW-2){1'b0}}};
   end

   // Special-operand classification: NaN first, then zero, then negative, then +inf
   always_comb begin
      w_special = 1'b1;
      w_sSp     = 1'b0;
      w_eSp     = '1;
      w_fracSp  = '0;
      w_invSp   = 1'b0;
      if (isSNAN_i || isQNAN_i) begin
         w_fracSp = QNAN_FRAC;
         w_invSp  = isSNAN_i;
      end else if (isZ_i) begin
         w_sSp = s_i;
         w_eSp = '0;
      end else if (s_i) begin
         w_fracSp = QNAN_FRAC;
         w_invSp  = 1'b1;
      end else if (!isInf_i) begin
         w_special = 1'b0;
      end
   end

   // One restoring step: bring down the next radicand pair and try subtracting {root,01}
   always_comb begin
      w_remSh    = {r_rem[REM_W-3:0], r_rad[RAD_W-1:RAD_W-2]};
      w_trial    = {1'b0, w_remSh} - {{(REM_W-ITERS-1){1'b0}}, r_root, 2'b01};
      w_trialNeg = w_trial[REM_W];
   end

   // Control FSM: accept in IDLE, count iterations, hold result in DONE until taken or killed
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (w_accept) begin
`ifdef LAMP_SQRT_EARLY_EXIT_EN
                  r_state <= w_special ? ST_DONE : ST_ITER;
`else
                  r_state <= ST_ITER;
`endif
               end
            end
            ST_ITER: begin
               if (kill_i) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == LAST_CNT)
                     r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (kill_i || ready_i)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Datapath: capture operand and special result at accept, then resolve one root bit per ITER cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rad       <= '0;
         r_rem       <= '0;
         r_root      <= '0;
         r_special   <= 1'b0;
         r_s         <= 1'b0;
         r_e         <= '0;
         r_fracSp    <= '0;
         r_invalid   <= 1'b0;
         r_isToRound <= 1'b0;
      end else if (w_accept) begin
         r_rad       <= w_rad;
         r_rem       <= '0;
         r_root      <= '0;
         r_special   <= w_special;
         r_s         <= w_special & w_sSp;
         r_e         <= w_special ? w_eSp : w_eNorm;
         r_fracSp    <= w_fracSp;
         r_invalid   <= w_special & w_invSp;
         r_isToRound <= !w_special;
      end else if (r_state == ST_ITER && !kill_i) begin
         r_rad  <= r_rad << 2;
         r_rem  <= w_trialNeg ? w_remSh : w_trial[REM_W-1:0];
         r_root <= {r_root[ITERS-2:0], !w_trialNeg};
      end
   end

   assign ready_o       = (r_state == ST_IDLE) && !rst;
   assign valid_o       = (r_state == ST_DONE) && !rst;
   assign s_res_o       = r_s && !rst;
   assign e_res_o       = rst ? '0 : r_e;
   assign f_res_o       = rst       ? '0 :
                          r_special ? {2'b00, r_fracSp, 3'b000} :
                                      {1'b0, r_root, |r_rem};
   assign isToRound_o   = r_isToRound && !rst;
   assign invalid_o     = r_invalid && !rst;
   assign isOverflow_o  = 1'b0;
   assign isUnderflow_o = 1'b0;

endmodule

// File: tb/tb_lamp_fpu_sqrt_iter.sv
// tb_lamp_fpu_sqrt_iter: directed self-checking bench for lamp_fpu_sqrt_iter
// (default E_DW=8, F_DW=7 so ITERS=10). Honors LAMP_SQRT_EARLY_EXIT_EN for latency.
module tb_lamp_fpu_sqrt_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic        ready_o;
   logic        kill_i;
   logic        s_i;
   logic [7:0]  extF_i;
   logic [8:0]  extE_i;
   logic [2:0]  nlz_i;
   logic        isZ_i, isInf_i, isSNAN_i, isQNAN_i;
   logic        valid_o;
   logic        ready_i;
   logic        s_res_o;
   logic [7:0]  e_res_o;
   logic [11:0] f_res_o;
   logic        isToRound_o;
   logic        invalid_o;
   logic        isOverflow_o, isUnderflow_o;

   int vectors     = 0;
   int miscompares = 0;
   int lat;
   int specLat;
   logic sawValid;

   lamp_fpu_sqrt_iter dut (
      .clk(clk), .rst(rst),
      .valid_i(valid_i), .ready_o(ready_o), .kill_i(kill_i),
      .s_i(s_i), .extF_i(extF_i), .extE_i(extE_i), .nlz_i(nlz_i),
      .isZ_i(isZ_i), .isInf_i(isInf_i), .isSNAN_i(isSNAN_i), .isQNAN_i(isQNAN_i),
      .valid_o(valid_o), .ready_i(ready_i),
      .s_res_o(s_res_o), .e_res_o(e_res_o), .f_res_o(f_res_o),
      .isToRound_o(isToRound_o), .invalid_o(invalid_o),
      .isOverflow_o(isOverflow_o), .isUnderflow_o(isUnderflow_o)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one operand, then count rising edges until valid_o (bounded at 100)
   task automatic applyStimulus(input logic s, input logic [8:0] e, input logic [7:0] f,
                                input logic [2:0] nlz, input logic z, input logic inf,
                                input logic sn, input logic qn, output int latency);
      checkOutput("ready_before_accept", {31'd0, ready_o}, 32'd1);
      s_i = s; extE_i = e; extF_i = f; nlz_i = nlz;
      isZ_i = z; isInf_i = inf; isSNAN_i = sn; isQNAN_i = qn;
      valid_i = 1'b1;
      latency = 0;
      do begin
         @(posedge clk); #1;
         valid_i = 1'b0;
         latency++;
      end while (!valid_o && latency < 100);
   endtask

   task automatic takeResult();
      ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0;
      checkOutput("valid_after_take", {31'd0, valid_o}, 32'd0);
      checkOutput("ready_after_take", {31'd0, ready_o}, 32'd1);
   endtask

   task automatic checkResult(input string tag, input int latency, input int expLat,
                              input logic s, input logic [7:0] e, input logic [11:0] f,
                              input logic toRound, input logic inv);
      checkOutput({tag, "_latency"}, latency, expLat);
      checkOutput({tag, "_s"}, {31'd0, s_res_o}, {31'd0, s});
      checkOutput({tag, "_e"}, {24'd0, e_res_o}, {24'd0, e});
      checkOutput({tag, "_f"}, {20'd0, f_res_o}, {20'd0, f});
      checkOutput({tag, "_toRound"}, {31'd0, isToRound_o}, {31'd0, toRound});
      checkOutput({tag, "_invalid"}, {31'd0, invalid_o}, {31'd0, inv});
      checkOutput({tag, "_ovf_unf"}, {30'd0, isOverflow_o, isUnderflow_o}, 32'd0);
   endtask

   initial begin
`ifdef LAMP_SQRT_EARLY_EXIT_EN
      specLat = 1;
`else
      specLat = 11;
`endif
      rst = 1'b1; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b0;
      s_i = 1'b0; extF_i = '0; extE_i = '0; nlz_i = '0;
      isZ_i = 1'b0; isInf_i = 1'b0; isSNAN_i = 1'b0; isQNAN_i = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_ready", {31'd0, ready_o}, 32'd0);
      checkOutput("reset_valid", {31'd0, valid_o}, 32'd0);
      checkOutput("reset_f", {20'd0, f_res_o}, 32'd0);
      checkOutput("reset_e", {24'd0, e_res_o}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("post_reset_ready", {31'd0, ready_o}, 32'd1);

      // sqrt(4.0) = 2.0
      applyStimulus(1'b0, 9'd129, 8'h80, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, lat);
      checkResult("sqrt4", lat, 11, 1'b0, 8'd128, 12'h400, 1'b1, 1'b0);
      takeResult();

      // sqrt(2.0) = 1.0110101 with sticky
      applyStimulus(1'b0, 9'd128, 8'h80, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, lat);
      checkResult("sqrt2", lat, 11, 1'b0, 8'd127, 12'h5A9, 1'b1, 1'b0);
      takeResult();

      // sqrt(9.0) = 3.0, odd exponent, exact
      applyStimulus(1'b0, 9'd130, 8'h90, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, lat);
      checkResult("sqrt9", lat, 11, 1'b0, 8'd128, 12'h600, 1'b1, 1'b0);
      takeResult();

      // Smallest subnormal 2^-133
      applyStimulus(1'b0, 9'd1, 8'h01, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, lat);
      checkResult("subnormal", lat, 11, 1'b0, 8'd60, 12'h5A9, 1'b1, 1'b0);
      takeResult();

      // -1.0 -> QNaN, invalid
      applyStimulus(1'b1, 9'd127, 8'h80, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, lat);
      checkResult("neg_one", lat, specLat, 1'b0, 8'hFF, 12'h200, 1'b0, 1'b1);
      takeResult();

      // -0 -> -0
      applyStimulus(1'b1, 9'd1, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, lat);
      checkResult("neg_zero", lat, specLat, 1'b1, 8'h00, 12'h000, 1'b0, 1'b0);
      takeResult();

      // +inf -> +inf
      applyStimulus(1'b0, 9'd255, 8'h80, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, lat);
      checkResult("pos_inf", lat, specLat, 1'b0, 8'hFF, 12'h000, 1'b0, 1'b0);
      takeResult();

      // -inf -> QNaN, invalid
      applyStimulus(1'b1, 9'd255, 8'h80, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, lat);
      checkResult("neg_inf", lat, specLat, 1'b0, 8'hFF, 12'h200, 1'b0, 1'b1);
      takeResult();

      // sNaN -> QNaN, invalid
      applyStimulus(1'b1, 9'd255, 8'hA0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, lat);
      checkResult("snan", lat, specLat, 1'b0, 8'hFF, 12'h200, 1'b0, 1'b1);
      takeResult();

      // qNaN -> QNaN, not invalid
      applyStimulus(1'b0, 9'd255, 8'hC0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, lat);
      checkResult("qnan", lat, specLat, 1'b0, 8'hFF, 12'h200, 1'b0, 1'b0);
      takeResult();

      // Back-pressure: result must hold for 5 cycles with ready_i low
      applyStimulus(1'b0, 9'd128, 8'h80, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, lat);
      checkOutput("bp_latency", lat, 11);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checkOutput("bp_valid", {31'd0, valid_o}, 32'd1);
         checkOutput("bp_ready", {31'd0, ready_o}, 32'd0);
         checkOutput("bp_f", {20'd0, f_res_o}, 32'h5A9);
         checkOutput("bp_e", {24'd0, e_res_o}, 32'd127);
      end
      takeResult();
      applyStimulus(1'b0, 9'd129, 8'h80, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, lat);
      checkResult("bp_second", lat, 11, 1'b0, 8'd128, 12'h400, 1'b1, 1'b0);
      takeResult();

      // Kill at iteration 4
      s_i = 1'b0; extE_i = 9'd128; extF_i = 8'h80; nlz_i = 3'd0;
      isZ_i = 1'b0; isInf_i = 1'b0; isSNAN_i = 1'b0; isQNAN_i = 1'b0;
      valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      kill_i = 1'b1;
      @(posedge clk); #1;
      kill_i = 1'b0;
      checkOutput("kill_ready", {31'd0, ready_o}, 32'd1);
      checkOutput("kill_valid", {31'd0, valid_o}, 32'd0);
      sawValid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (valid_o) sawValid = 1'b1;
      end
      checkOutput("kill_no_result", {31'd0, sawValid}, 32'd0);
      applyStimulus(1'b0, 9'd129, 8'h80, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, lat);
      checkResult("after_kill", lat, 11, 1'b0, 8'd128, 12'h400, 1'b1, 1'b0);
      takeResult();

      // kill_i with valid_i in IDLE: operand refused
      s_i = 1'b1; extE_i = 9'd127; isZ_i = 1'b0;
      valid_i = 1'b1; kill_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0; kill_i = 1'b0;
      checkOutput("idle_kill_ready", {31'd0, ready_o}, 32'd1);
      sawValid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (valid_o) sawValid = 1'b1;
      end
      checkOutput("idle_kill_no_result", {31'd0, sawValid}, 32'd0);

      // Reset mid-operation
      applyStimulus(1'b0, 9'd128, 8'h80, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, lat);
      takeResult();
      s_i = 1'b0; extE_i = 9'd129; extF_i = 8'h80;
      valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("midrst_ready", {31'd0, ready_o}, 32'd0);
      checkOutput("midrst_valid", {31'd0, valid_o}, 32'd0);
      checkOutput("midrst_f", {20'd0, f_res_o}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("midrst_ready_after", {31'd0, ready_o}, 32'd1);
      applyStimulus(1'b0, 9'd129, 8'h80, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, lat);
      checkResult("after_midrst", lat, 11, 1'b0, 8'd128, 12'h400, 1'b1, 1'b0);
      takeResult();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
